// File: rtl/spi_flash_id_responder_if.sv
// SPI bus bundle between spi_master and the flash ID responder.
// Signal names match the original flat SPI ports.
interface spi_flash_id_responder_if;
  logic SPICLK;
  logic SPIMOSI;
  logic SPISS_N;
  logic SPIMISO;

  modport master (
    output SPICLK,
    output SPIMOSI,
    output SPISS_N,
    input  SPIMISO
  );

  modport slave (
    input  SPICLK,
    input  SPIMOSI,
    input  SPISS_N,
    output SPIMISO
  );
endinterface

// File: rtl/spi_flash_id_responder.sv
// SPI mode-0 slave answering RDID/RDSR like an M25P16. The bus is oversampled
// in the clk domain and the response is shifted out on SPIMISO.
module spi_flash_id_responder #(
  parameter logic [7:0] MFR_ID   = 8'h20,
  parameter logic [7:0] MEM_TYPE = 8'h20,
  parameter logic [7:0] MEM_CAP  = 8'h15,
  parameter logic [7:0] STATUS   = 8'h00
) (
  input  logic                    clk,
  input  logic                    reset,
  spi_flash_id_responder_if.slave spi,
  output logic                    busy,
  output logic                    cmd_done,
  output logic [7:0]              cmd
);
  localparam logic [7:0] OP_RDID = 8'h9F;
  localparam logic [7:0] OP_RDSR = 8'h05;

  typedef enum logic [1:0] {IDLE, CMD, RESP, IGNORE} state_t;
  state_t state, state_nx;

  // Synchronizers; the third SPICLK stage is the edge-detect history
  logic [2:0] sclk_sync;
  logic [1:0] mosi_sync;
  logic [1:0] ss_sync;
  logic       sclk_s, sclk_d, mosi_s, ss_s;
  logic       rise, fall;

  logic [7:0] op_sr;
  logic [7:0] resp_sr;
  logic [2:0] bit_cnt;
  logic [1:0] byte_idx;
  logic       is_rdid;
  logic       miso_q;

  logic [7:0] op_next;
  logic       op_known;
  logic [1:0] idx_next;
  logic [7:0] next_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_sync   <= '1;
    end else begin
      sclk_sync <= {sclk_sync[1:0], spi.SPICLK};
      mosi_sync <= {mosi_sync[0], spi.SPIMOSI};
      ss_sync   <= {ss_sync[0], spi.SPISS_N};
    end
  end

  assign sclk_s = sclk_sync[1];
  assign sclk_d = sclk_sync[2];
  assign mosi_s = mosi_sync[1];
  assign ss_s   = ss_sync[1];
  assign rise   = sclk_s & ~sclk_d;
  assign fall   = ~sclk_s & sclk_d;

  always_comb begin
    op_next  = {op_sr[6:0], mosi_s};
    op_known = (op_next == OP_RDID) || (op_next == OP_RDSR);
    idx_next = (byte_idx == 2'd3) ? 2'd3 : byte_idx + 2'd1;
    if (!is_rdid) begin
      next_byte = STATUS;
    end else begin
      case (idx_next)
        2'd0:    next_byte = MFR_ID;
        2'd1:    next_byte = MEM_TYPE;
        2'd2:    next_byte = MEM_CAP;
        default: next_byte = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Deselect wins over any edge strobe arriving in the same cycle
  always_comb begin
    state_nx = state;
    cmd_done = 1'b0;
    busy     = (state != IDLE);
    if (ss_s) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: state_nx = CMD;
        CMD: begin
          if (rise && (bit_cnt == 3'd7)) begin
            cmd_done = 1'b1;
            state_nx = op_known ? RESP : IGNORE;
          end
        end
        RESP:    state_nx = RESP;
        IGNORE:  state_nx = IGNORE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_sr    <= '0;
      resp_sr  <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      is_rdid  <= 1'b0;
      miso_q   <= 1'b0;
      cmd      <= '0;
    end else if (ss_s) begin
      op_sr    <= '0;
      resp_sr  <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      is_rdid  <= 1'b0;
      miso_q   <= 1'b0;
    end else begin
      case (state)
        CMD: begin
          miso_q <= 1'b0;
          if (rise) begin
            op_sr   <= op_next;
            bit_cnt <= bit_cnt + 3'd1;
            if (cmd_done) begin
              cmd      <= op_next;
              byte_idx <= '0;
              is_rdid  <= (op_next == OP_RDID);
              resp_sr  <= (op_next == OP_RDID) ? MFR_ID :
                          (op_next == OP_RDSR) ? STATUS : 8'h00;
            end
          end
        end
        RESP: begin
          // bit_cnt wrapped to 0 on the 8th opcode rise, so it now counts falls
          if (fall) begin
            miso_q  <= resp_sr[7];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              resp_sr  <= next_byte;
              byte_idx <= idx_next;
            end else begin
              resp_sr <= {resp_sr[6:0], 1'b0};
            end
          end
        end
        default: begin
          bit_cnt <= (state == IDLE) ? 3'd0 : bit_cnt;
          miso_q  <= 1'b0;
        end
      endcase
    end
  end

  assign spi.SPIMISO = miso_q;

endmodule
